// File: rtl/cog_pkg.sv
// Shared types and helpers for the centre-of-gravity segment extractor.
//   state_t      : segment FSM state (idle / waiting for a run / inside a run)
//   hold_flags_t : per-beat flags kept in the one-entry lookahead register
//   is_fg        : foreground test on a mask component, both operands zero-extended
package cog_pkg;

  // Widest image/mask component that is_fg accepts.
  localparam int unsigned MaxDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFig,
    StInFig
  } state_t;

  typedef struct packed {
    logic valid;  // entry holds an unemitted beat
    logic fg;     // mask at or above threshold
    logic sof;    // first pixel of a run
    logic tlast;  // last beat of its line
    logic eof;    // last beat of the frame
  } hold_flags_t;

  function automatic logic is_fg(input logic [MaxDataWidth-1:0] mask,
                                 input logic [MaxDataWidth-1:0] thresh);
    return mask >= thresh;
  endfunction

endpackage

// File: rtl/cog_line_counter.sv
// Pixel/line position tracking for the segment extractor.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   beat_i            : a beat is being processed this cycle
//   tuser_i, tlast_i  : frame start / line end markers of the current beat
//   mid_frame_i       : a frame is already in progress (tuser then restarts it)
//   x_o, y_o, eof_o   : position of the current beat and its end-of-frame flag
//   line_err_o        : registered pulse on a line length mismatch or frame restart
module cog_line_counter #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 1024,
  parameter int unsigned XW     = 11,
  parameter int unsigned YW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          beat_i,
  input  logic          tuser_i,
  input  logic          tlast_i,
  input  logic          mid_frame_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          eof_o,
  output logic          line_err_o
);

  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          err_q, err_d;

  always_comb begin
    // A tuser beat is always pixel (0, 0), whatever the counters say.
    x_o   = tuser_i ? '0 : x_q;
    y_o   = tuser_i ? '0 : y_q;
    eof_o = tlast_i & (y_o == YLast);
    x_d   = x_q;
    y_d   = y_q;
    err_d = 1'b0;
    if (beat_i) begin
      // tlast is authoritative for counting; the nominal width only flags errors.
      x_d = tlast_i ? '0 : x_o + XW'(1);
      if (eof_o) begin
        y_d = '0;
      end else if (tlast_i) begin
        y_d = y_o + YW'(1);
      end else begin
        y_d = y_o;
      end
      err_d = (tlast_i != (x_o == XLast)) | (tuser_i & mid_frame_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign line_err_o = err_q;

endmodule

// File: rtl/cog_segment_extractor.sv
// Foreground run extractor for the CoG path. Takes AXI-Stream beats carrying
// {mask, image}, finds every foreground run on each line and re-emits the pixels
// through registered outputs with exact run start/end flags and position data.
//   i_sys_clk, i_sys_reset  : clock, synchronous active-high reset
//   s_axis_*                : input stream (tuser = frame start, tlast = line end)
//   data_image_reg/valid    : emitted pixel, valid when it belongs to a run
//   start/end_of_fig_reg    : first/last pixel of a run
//   start_point_reg         : x of the latest run start
//   line_idx_reg            : y of the emitted pixel
//   o_end_of_line/frame_reg : emitted beat closed a line / the frame
//   o_new_frame_reg         : pulse when a tuser beat is taken
//   o_line_err_reg          : pulse on line length mismatch or mid-frame restart
//   o_fig_len/short_reg     : run length and too-short flag, built only when the
//                             COG_MIN_LEN_EN macro is defined (otherwise tied 0)
module cog_segment_extractor
  import cog_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            WIDTH       = 1280,
  parameter int unsigned            HEIGHT      = 1024,
  parameter logic [DATA_WIDTH-1:0]  MASK_THRESH = 8'h80,
  parameter int unsigned            MIN_LEN     = 3,
  localparam int unsigned           XW          = $clog2(WIDTH),
  localparam int unsigned           YW          = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_reset,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   data_image_reg,
  output logic                    data_valid_reg,
  output logic                    start_of_fig_reg,
  output logic                    end_of_fig_reg,
  output logic [XW-1:0]           start_point_reg,
  output logic [YW-1:0]           line_idx_reg,
  output logic                    o_end_of_line_reg,
  output logic                    o_end_of_frame_reg,
  output logic                    o_new_frame_reg,
  output logic                    o_line_err_reg,
  output logic [XW-1:0]           o_fig_len_reg,
  output logic                    o_fig_short_reg
);

  logic                  tready_q;
  state_t                state_q, state_d, state_eff;
  hold_flags_t           hold_q, hold_d;
  logic [DATA_WIDTH-1:0] hold_img_q, hold_img_d;
  logic [XW-1:0]         hold_x_q, hold_x_d;
  logic [YW-1:0]         hold_y_q, hold_y_d;

  logic [DATA_WIDTH-1:0] img_q, img_d;
  logic                  dv_q, dv_d, sof_q, sof_d, eofig_q, eofig_d;
  logic [XW-1:0]         sp_q, sp_d;
  logic [YW-1:0]         ly_q, ly_d;
  logic                  eol_q, eol_d, eofr_q, eofr_d, nf_q, nf_d;

  logic                  acc, emit, proc, fg_in, run_end;
  logic [XW-1:0]         x_cur;
  logic [YW-1:0]         y_cur;
  logic                  eof_cur;

  assign acc   = s_axis_tvalid & tready_q;
  assign fg_in = is_fg(MaxDataWidth'(s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH]),
                       MaxDataWidth'(MASK_THRESH));
  // A held beat leaves when its successor arrives, or on its own after a tlast.
  assign emit  = hold_q.valid & (hold_q.tlast | acc);
  // Leaving the frame happens in the same cycle the eof beat is emitted, so a
  // beat arriving alongside it is judged as if already idle.
  assign state_eff = (emit & hold_q.eof) ? StIdle : state_q;
  assign proc  = acc & ((state_eff != StIdle) | s_axis_tuser);
  // tuser on the incoming beat can only be a restart here: a non-tlast held beat
  // implies a frame is open.
  assign run_end = hold_q.fg & (hold_q.tlast | ~fg_in | s_axis_tuser);

  cog_line_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_line_counter (
    .clk_i       (i_sys_clk),
    .rst_i       (i_sys_reset),
    .beat_i      (proc),
    .tuser_i     (s_axis_tuser),
    .tlast_i     (s_axis_tlast),
    .mid_frame_i (state_eff != StIdle),
    .x_o         (x_cur),
    .y_o         (y_cur),
    .eof_o       (eof_cur),
    .line_err_o  (o_line_err_reg)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_img_d = hold_img_q;
    hold_x_d   = hold_x_q;
    hold_y_d   = hold_y_q;
    img_d      = img_q;
    sp_d       = sp_q;
    ly_d       = ly_q;
    dv_d       = 1'b0;
    sof_d      = 1'b0;
    eofig_d    = 1'b0;
    eol_d      = 1'b0;
    eofr_d     = 1'b0;
    nf_d       = proc & s_axis_tuser;

    if (emit) begin
      dv_d         = hold_q.fg;
      sof_d        = hold_q.sof;
      eofig_d      = run_end;
      eol_d        = hold_q.tlast;
      eofr_d       = hold_q.eof;
      img_d        = hold_img_q;
      ly_d         = hold_y_q;
      if (hold_q.sof) sp_d = hold_x_q;
      hold_d.valid = 1'b0;
      if (hold_q.eof) state_d = StIdle;
    end

    if (proc) begin
      hold_d.valid = 1'b1;
      hold_d.fg    = fg_in;
      hold_d.sof   = fg_in & ((x_cur == '0) | (state_eff != StInFig));
      hold_d.tlast = s_axis_tlast;
      hold_d.eof   = eof_cur;
      hold_img_d   = s_axis_tdata[DATA_WIDTH-1:0];
      hold_x_d     = x_cur;
      hold_y_d     = y_cur;
      state_d      = (fg_in & ~s_axis_tlast) ? StInFig : StWaitFig;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      tready_q   <= 1'b0;
      state_q    <= StIdle;
      hold_q     <= '0;
      hold_img_q <= '0;
      hold_x_q   <= '0;
      hold_y_q   <= '0;
      img_q      <= '0;
      dv_q       <= 1'b0;
      sof_q      <= 1'b0;
      eofig_q    <= 1'b0;
      sp_q       <= '0;
      ly_q       <= '0;
      eol_q      <= 1'b0;
      eofr_q     <= 1'b0;
      nf_q       <= 1'b0;
    end else begin
      tready_q   <= 1'b1;
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_img_q <= hold_img_d;
      hold_x_q   <= hold_x_d;
      hold_y_q   <= hold_y_d;
      img_q      <= img_d;
      dv_q       <= dv_d;
      sof_q      <= sof_d;
      eofig_q    <= eofig_d;
      sp_q       <= sp_d;
      ly_q       <= ly_d;
      eol_q      <= eol_d;
      eofr_q     <= eofr_d;
      nf_q       <= nf_d;
    end
  end

`ifdef COG_MIN_LEN_EN
  localparam logic [31:0] MinLen32 = 32'(MIN_LEN);

  logic [XW-1:0] run_q, run_d, run_cur, len_q, len_d;
  logic          short_q, short_d;

  always_comb begin
    // Saturate rather than wrap so an over-long run never looks short.
    run_cur = hold_q.sof ? XW'(1) : ((run_q == '1) ? run_q : run_q + XW'(1));
    run_d   = run_q;
    len_d   = len_q;
    short_d = short_q;
    if (emit & hold_q.fg) begin
      run_d = run_cur;
      if (run_end) begin
        len_d   = run_cur;
        short_d = 32'(run_cur) < MinLen32;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      run_q   <= '0;
      len_q   <= '0;
      short_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      len_q   <= len_d;
      short_q <= short_d;
    end
  end

  assign o_fig_len_reg   = len_q;
  assign o_fig_short_reg = short_q;
`else
  logic unused_min_len;
  assign unused_min_len  = ^MIN_LEN;
  assign o_fig_len_reg   = '0;
  assign o_fig_short_reg = 1'b0;
`endif

  assign s_axis_tready      = tready_q;
  assign data_image_reg     = img_q;
  assign data_valid_reg     = dv_q;
  assign start_of_fig_reg   = sof_q;
  assign end_of_fig_reg     = eofig_q;
  assign start_point_reg    = sp_q;
  assign line_idx_reg       = ly_q;
  assign o_end_of_line_reg  = eol_q;
  assign o_end_of_frame_reg = eofr_q;
  assign o_new_frame_reg    = nf_q;

endmodule

// File: doc/cog_segment_extractor.md
Name: cog_segment_extractor

Overview:
- Parametrised successor front end for the centre-of-gravity (CoG) path.
- Accepts AXI-Stream beats carrying image and mask bytes.
- Finds every foreground run of any length on each line, including runs that touch the line end or are a single pixel.
- Emits each run as a registered pixel stream with exact start/end flags, start x, line index and line/frame markers.
- Uses tlast/tuser as ground truth and checks them against WIDTH/HEIGHT.

Parameters:
- DATA_WIDTH, 8, width of both image and mask components.
- WIDTH, 1280, nominal pixels per line.
- HEIGHT, 1024, nominal lines per frame.
- MASK_THRESH, 8'h80, a pixel is foreground when mask >= MASK_THRESH (unsigned).
- MIN_LEN, 3, minimum valid run length; used only with COG_MIN_LEN_EN.
- XW, $clog2(WIDTH), x/length width (local).
- YW, $clog2(HEIGHT), y width (local).

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_reset  in  1  synchronous active-high reset.
- s_axis_tdata  in  2*DATA_WIDTH  [DATA_WIDTH-1:0] image, upper half mask.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tuser  in  1  first beat of frame.
- s_axis_tlast  in  1  last beat of line.
- s_axis_tready  out  1  ready.
- data_image_reg  out  DATA_WIDTH  segment pixel.
- data_valid_reg  out  1  data_image_reg belongs to a segment.
- start_of_fig_reg  out  1  first pixel of segment (qualified by data_valid_reg).
- end_of_fig_reg  out  1  last pixel of segment (qualified by data_valid_reg).
- start_point_reg  out  XW  x of segment first pixel, held until next start.
- line_idx_reg  out  YW  y of emitted pixel.
- o_end_of_line_reg  out  1  emitted beat was line's last.
- o_end_of_frame_reg  out  1  emitted beat was frame's last.
- o_new_frame_reg  out  1  pulse, tuser beat accepted.
- o_line_err_reg  out  1  pulse, line length mismatch.
- o_fig_len_reg  out  XW  run length at end_of_fig (COG_MIN_LEN_EN only).
- o_fig_short_reg  out  1  run shorter than MIN_LEN (COG_MIN_LEN_EN only).

Behaviour:
- **Reset:** while i_sys_reset is high, every output and register is 0 and the state is IDLE. s_axis_tready is registered and goes to 1 on the first clock after reset is released; it is never deasserted otherwise (no backpressure downstream).
- **Accept:** a beat is accepted when tvalid & tready. fg = mask >= MASK_THRESH.
- **Hold register:** one-entry lookahead holding image, fg, x, y, tlast and eof flag.
  - A held beat is emitted exactly once, on the clock edge after the next accept.
  - A held beat with tlast set is instead emitted on the edge after its own accept (flush), independent of tvalid.
  - A new accept in the flush cycle simply refills the hold register.
- **Emission of held beat H** (registered, all outputs update together):
  - data_valid = H.fg.
  - start_of_fig = H.fg & (H.x==0 | previous beat bg).
  - end_of_fig = H.fg & (H.tlast | next beat bg).
  - start_point updates on start_of_fig.
  - o_end_of_line = H.tlast.
  - o_end_of_frame = H.tlast & H.y==HEIGHT-1.
  - Non-fg beats produce no data_valid but still carry eol/eof.
  - Single-pixel run: start and end both 1.
- **Latency:** 1 cycle after the following accept; 1 cycle after accept for tlast beats.
- **Counters:** x increments per accept and resets to 0 after tlast. y increments on tlast and resets after the eof beat or on tuser.
- **Line error:** o_line_err pulses on a tlast beat with x != WIDTH-1, or on the beat at x == WIDTH-1 without tlast. Counting still follows tlast.
- **FSM (cog_pkg::state_t):**
  - IDLE: beats discarded until a tuser beat → o_new_frame, x=y=0, that beat processed, go to WAIT_FIG (or IN_FIG if fg).
  - WAIT_FIG: fg → IN_FIG.
  - IN_FIG: bg or tlast → WAIT_FIG.
  - Emission of the eof beat → IDLE.
- **Mid-frame tuser:** any state outside IDLE.
  - Held beat emitted with end_of_fig forced if fg.
  - o_line_err pulses.
  - Counters restart at 0; o_new_frame pulses.
- **Reset mid-operation:** the held beat is dropped and no end_of_fig is produced.

Optional Feature:
- COG_MIN_LEN_EN defined:
  - An XW-bit run counter saturates at 2^XW-1.
  - On end_of_fig, o_fig_len_reg = run length and o_fig_short_reg = len < MIN_LEN.
  - Pixels are still emitted; downstream discards the run.
- Undefined: both outputs are tied 0 and the counter is absent.

Decomposition:
- cog_pkg:
  - state_t enum {IDLE, WAIT_FIG, IN_FIG}.
  - Hold-register struct typedef.
  - Function is_fg(mask, thresh).
- Sub-module cog_line_counter: x/y counters, tlast/tuser handling, line error detection.

Test Plan:
- WIDTH=8, HEIGHT=2, MASK_THRESH=8'h80, tuser then line 0 mask 00,FF,FF,FF,00,00,00,00, image 10..17 → data_valid on 11,12,13; start on 11 with start_point=1; end on 13; eol on 8th beat.
- Run touching line end, mask 00,00,00,00,00,00,FF,FF → start at x=6, end on x=7 together with o_end_of_line; next line starts in WAIT_FIG.
- Single-pixel run at x=3 and two runs on one line (x=1..2, x=5..6) → start and end both set at x=3; two start/end pairs with start_point 1 then 5.
- tvalid toggling 1,0,0,1 inside a run plus tlast at x=5 → o_line_err pulse, no duplicate or missing pixels, y increments.
- Second tuser mid-line inside a run → end_of_fig on held pixel, o_new_frame, x restarts at 0; reset asserted mid-run → all outputs 0 the next cycle.
- With COG_MIN_LEN_EN, MIN_LEN=3, runs of length 2 and 4 → o_fig_len 2 and o_fig_short 1, then o_fig_len 4 and o_fig_short 0.
